// File: rtl/key_digit_entry.sv
// -----------------------------------------------------------------------------
// key_digit_entry
//
// Turns keyboard decoder events into a decimal entry buffer. Digit keys (main
// row or keypad) shift a BCD digit in at the low end, Backspace drops the most
// recent digit, Esc clears the buffer and Enter commits it. A commit runs a
// sequential BCD-to-binary conversion, one digit per cycle starting from the
// most significant nibble slot, then publishes the result with a one-cycle
// valid pulse and empties the buffer.
//
// Ports
//   clk          system clock (same domain as the keyboard decoder)
//   rst_n        asynchronous, active-low reset
//   key_down     per-key held state, indexed by {ext,scancode}
//   last_change  {ext,scancode} of the most recent decoder event
//   key_valid    one-cycle event strobe from the decoder
//   bcd          entry buffer, bcd[3:0] holds the most recently typed digit
//   digit_count  number of digits in the buffer (0..DIGITS)
//   busy         high while a conversion is running; key events are dropped
//   value        last committed binary value, held until the next commit
//   value_valid  one-cycle pulse when value updates
//   err          one-cycle pulse on a rejected key (full buffer / empty Enter)
//
// Handshake: the decoder offers an event by raising key_valid for exactly one
// cycle; there is no back-pressure. An event is a press when the key_down bit
// addressed by last_change is set in that same cycle. Events arriving while
// busy (or during the commit cycle) are discarded without err.
// -----------------------------------------------------------------------------
module key_digit_entry #(
   parameter int DIGITS = 4,
   parameter int VW     = 14,
   parameter int CW     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [511:0]          key_down,
   input  logic [8:0]            last_change,
   input  logic                  key_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [CW-1:0]         digit_count,
   output logic                  busy,
   output logic [VW-1:0]         value,
   output logic                  value_valid,
   output logic                  err
);

   localparam int BW = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DIGITS);
   localparam logic [IW-1:0] TOP_INDEX  = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // conversion datapath
   logic [VW-1:0] acc;
   logic [IW-1:0] idx;

   // next values of every register
   logic [BW-1:0] bcd_next;
   logic [CW-1:0] count_next;
   logic          busy_next;
   logic [VW-1:0] value_next;
   logic          value_valid_next;
   logic          err_next;
   logic [VW-1:0] acc_next;
   logic [IW-1:0] idx_next;

   // -------------------------------------------------------------------------
   // Key decode
   // -------------------------------------------------------------------------
   logic       press;
   logic       is_digit;
   logic [3:0] digit;
   logic       is_enter;
   logic       is_bksp;
   logic       is_esc;

   assign press    = key_valid && key_down[last_change];
   assign is_enter = (last_change == 9'h05A) || (last_change == 9'h15A);
   assign is_bksp  = (last_change == 9'h066);
   assign is_esc   = (last_change == 9'h076);

   always_comb begin
      is_digit = 1'b1;
      digit    = 4'd0;
      case (last_change)
         9'h045, 9'h070: digit = 4'd0;
         9'h016, 9'h069: digit = 4'd1;
         9'h01E, 9'h072: digit = 4'd2;
         9'h026, 9'h07A: digit = 4'd3;
         9'h025, 9'h06B: digit = 4'd4;
         9'h02E, 9'h073: digit = 4'd5;
         9'h036, 9'h074: digit = 4'd6;
         9'h03D, 9'h06C: digit = 4'd7;
         9'h03E, 9'h075: digit = 4'd8;
         9'h046, 9'h07D: digit = 4'd9;
         default:        is_digit = 1'b0;
      endcase
   end

   // Digit currently being folded in; idx counts down from the top slot, so
   // leading zero slots of a short entry simply contribute nothing.
   logic [3:0]    cur_digit;
   logic [VW-1:0] acc_sum;

   assign cur_digit = 4'(bcd >> {idx, 2'b00});
   // acc*10 as (acc<<3)+(acc<<1); width stays VW, which holds 10^DIGITS-1.
   assign acc_sum   = (acc << 3) + (acc << 1) + VW'(cur_digit);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ENTRY;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         ST_ENTRY: begin
            if (press && is_enter && (digit_count != '0)) begin
               state_next = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            if (idx == '0) begin
               state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            state_next = ST_ENTRY;
         end
         default: begin
            state_next = ST_ENTRY;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output / datapath next values. Everything leaving the block is
   // registered, so this process only prepares the values captured on the
   // next edge.
   // -------------------------------------------------------------------------
   always_comb begin
      bcd_next         = bcd;
      count_next       = digit_count;
      busy_next        = busy;
      value_next       = value;
      value_valid_next = 1'b0;
      err_next         = 1'b0;
      acc_next         = acc;
      idx_next         = idx;

      case (state)
         ST_ENTRY: begin
            if (press) begin
               if (is_digit) begin
                  if (digit_count < FULL_COUNT) begin
                     bcd_next   = (bcd << 4) | BW'(digit);
                     count_next = digit_count + CW'(1);
                  end else begin
                     err_next = 1'b1;
                  end
               end else if (is_bksp) begin
                  if (digit_count != '0) begin
                     bcd_next   = bcd >> 4;
                     count_next = digit_count - CW'(1);
                  end
               end else if (is_esc) begin
                  bcd_next   = '0;
                  count_next = '0;
               end else if (is_enter) begin
                  if (digit_count == '0) begin
                     err_next = 1'b1;
                  end else begin
                     acc_next  = '0;
                     idx_next  = TOP_INDEX;
                     busy_next = 1'b1;
                  end
               end
            end
         end
         ST_CONVERT: begin
            acc_next = acc_sum;
            if (idx == '0) begin
               // Last digit: publish now so value_valid is visible during
               // the commit cycle and busy drops at the same time.
               value_next       = acc_sum;
               value_valid_next = 1'b1;
               busy_next        = 1'b0;
            end else begin
               idx_next = idx - IW'(1);
            end
         end
         ST_COMMIT: begin
            bcd_next   = '0;
            count_next = '0;
            busy_next  = 1'b0;
         end
         default: begin
            busy_next = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath / output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd         <= '0;
         digit_count <= '0;
         busy        <= 1'b0;
         value       <= '0;
         value_valid <= 1'b0;
         err         <= 1'b0;
         acc         <= '0;
         idx         <= '0;
      end else begin
         bcd         <= bcd_next;
         digit_count <= count_next;
         busy        <= busy_next;
         value       <= value_next;
         value_valid <= value_valid_next;
         err         <= err_next;
         acc         <= acc_next;
         idx         <= idx_next;
      end
   end

endmodule
